button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream input stage for the fishing-game block controller: conditions raw push-button inputs before they drive the up/down/left/right controls.
- Per channel: 2-flop synchronizer, debounce state machine, counter.
- Three outputs per channel: debounced level (db), single-cycle press pulse (scen), auto-repeat pulse (mcen).
- Board channel map: bit0 up, bit1 down, bit2 left, bit3 right, bit4 centre.

Parameters:
NUM_BTN, 5, number of independent button channels
DEBOUNCE_CYCLES, 2500000, stable cycles required to accept a press or a release (25 ms at 100 MHz); must be >= 2
REPEAT_DELAY, 50000000, cycles a press must be held before auto-repeat starts; must be >= 2
REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses; must be >= 2
CNT_W, 26, per-channel counter width; must hold max(all three cycle parameters) - 1

Ports:
clk  in  1  system clock (100 MHz board clock)
rst  in  1  asynchronous, active-high reset
btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed
db  out  NUM_BTN  debounced level per channel
scen  out  NUM_BTN  one-clk pulse per accepted press
mcen  out  NUM_BTN  pulse on press, then periodic while held

Behaviour:
- Reset, clk and rst: reset rst, asynchronous, active-high; clock clk.
  - rst clears every synchronizer flop, counter and state register immediately; all channels go to INI.
  - db, scen and mcen are all 0 while rst is high, and 0 in the first cycle after release.
  - Reset mid-press: no pulse is emitted; the channel restarts from INI.
- Channels are fully independent; each has its own synchronizer, state and counter. There is no cross-channel priority.
- Synchronizer: btn_in -> s1 -> s2. The FSM sees only s2.
- FSM per channel, states INI, WQ, PRESS, HOLD, REPEAT, WR; cnt is CNT_W bits, unsigned.
  - INI: if s2 = 1, go to WQ with cnt <= 0; otherwise stay.
  - WQ (wait quiet): if s2 = 0, go to INI. Else if cnt == DEBOUNCE_CYCLES-1, go to PRESS. Else cnt++.
  - PRESS: lasts exactly 1 cycle; then go to HOLD with cnt <= 0, regardless of s2.
  - HOLD:
    - s2 = 0: go to WR with cnt <= 0.
    - s2 = 1 and cnt == REPEAT_DELAY-1: go to REPEAT with cnt <= 0.
    - Otherwise: cnt++.
  - REPEAT:
    - s2 = 0: go to WR with cnt <= 0.
    - s2 = 1 and cnt == REPEAT_PERIOD-1: cnt <= 0.
    - Otherwise: cnt++.
  - WR (wait release):
    - s2 = 1 (bounce): go to HOLD with cnt <= 0. No new scen.
    - s2 = 0 and cnt == DEBOUNCE_CYCLES-1: go to INI.
    - Otherwise: cnt++.
- Outputs are Moore decodes of registered state and cnt, with no combinational path from btn_in:
  - db = 1 in PRESS, HOLD, REPEAT and WR.
  - scen = 1 only in PRESS.
  - mcen = 1 in PRESS, and in REPEAT when cnt == REPEAT_PERIOD-1 and s2 = 1.
- Latency: with btn_in first sampled high at edge k and held:
  - PRESS (db, scen, mcen high) is visible after edge k+DEBOUNCE_CYCLES+2.
  - Press at cycle t gives mcen at t, t+REPEAT_DELAY+REPEAT_PERIOD, then every REPEAT_PERIOD.
- Release: db falls after s2 has been low for DEBOUNCE_CYCLES consecutive cycles, i.e. DEBOUNCE_CYCLES+2 edges after btn_in is first sampled low.
- Glitch rejection:
  - A high pulse shorter than DEBOUNCE_CYCLES+1 sampled cycles never produces scen.
  - A low glitch while held never produces a second scen.
- Counter never wraps: every state compares against a terminal value and clears or transitions before overflow.

Test Plan:
(Bench overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTN=5.)
1. Clean press: btn_in[2] rises before edge 0 and holds 8 cycles, then falls -> scen[2]=mcen[2]=1 only in the cycle after edge 6; db[2] rises after edge 6 and falls after edge 8+6=14; no other bit toggles.
2. Bounce reject: btn_in[0] high for 3 cycles, low 1, high 3, then low -> scen[0], mcen[0], db[0] stay 0 throughout.
3. Auto-repeat: btn_in[3] held 40 cycles, press cycle t -> mcen[3] high at t, t+13, t+16, t+19, ... (period 3); scen[3] high only at t; db[3]=1 throughout the hold.
4. Release bounce: after an accepted press on bit1, release with 2-cycle low / 1-cycle high chatter, then stay low -> no second scen[1]; db[1] stays 1 until 4 consecutive low s2 cycles, then falls.
5. Simultaneous: btn_in[0] and btn_in[4] rise on the same edge -> scen[0] and scen[4] assert in the same cycle; independent release timing is honoured per channel.
6. Reset mid-operation: assert rst during REPEAT on bit3 -> db, scen, mcen = 0 immediately (asynchronous); after rst drops with btn_in[3] still high, a fresh scen[3] appears exactly 6 edges later.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end: per-channel synchronizer, debounce FSM and repeat timer.
// Emits debounced level, single press pulse and auto-repeat pulse per channel.
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] db,
    output logic [NUM_BTN-1:0] scen,
    output logic [NUM_BTN-1:0] mcen
);

    typedef enum logic [2:0] {
        INI,
        WQ,
        PRESS,
        HOLD,
        REPEAT,
        WR
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic             s1;
        logic             s2;
        state_t           st;
        state_t           st_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                st  <= INI;
                cnt <= '0;
            end else begin
                s1  <= btn_in[i];
                s2  <= s1;
                st  <= st_nx;
                cnt <= cnt_nx;
            end
        end

        always_comb begin
            st_nx  = st;
            cnt_nx = cnt;
            unique case (st)
                INI: begin
                    if (s2) begin
                        st_nx  = WQ;
                        cnt_nx = '0;
                    end
                end
                WQ: begin
                    if (!s2) begin
                        st_nx = INI;
                    end else if (cnt == DB_LAST) begin
                        st_nx = PRESS;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                PRESS: begin
                    st_nx  = HOLD;
                    cnt_nx = '0;
                end
                HOLD: begin
                    if (!s2) begin
                        st_nx  = WR;
                        cnt_nx = '0;
                    end else if (cnt == RD_LAST) begin
                        st_nx  = REPEAT;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                REPEAT: begin
                    if (!s2) begin
                        st_nx  = WR;
                        cnt_nx = '0;
                    end else if (cnt == RP_LAST) begin
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                WR: begin
                    // A high sample here is release chatter: resume holding, no new press.
                    if (s2) begin
                        st_nx  = HOLD;
                        cnt_nx = '0;
                    end else if (cnt == DB_LAST) begin
                        st_nx = INI;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                default: begin
                    st_nx  = INI;
                    cnt_nx = '0;
                end
            endcase
        end

        assign db[i]   = (st == PRESS) || (st == HOLD) ||
                         (st == REPEAT) || (st == WR);
        assign scen[i] = (st == PRESS);
        assign mcen[i] = (st == PRESS) ||
                         ((st == REPEAT) && (cnt == RP_LAST) && s2);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and random bench for button_conditioner against a run-length model.
// Model tracks consecutive high/low sample runs and hold time per channel.
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_in = '0;
    logic [NB-1:0] db;
    logic [NB-1:0] scen;
    logic [NB-1:0] mcen;

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .CNT_W(26)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .db(db),
        .scen(scen),
        .mcen(mcen)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel      = 0;

    // reference model state
    logic [NB-1:0] ms1, ms2;
    logic [NB-1:0] e_db, e_scen, e_mcen;
    bit pressed [NB];
    bit jp      [NB];
    bit holding [NB];
    int hi_run  [NB];
    int lo_run  [NB];
    int hold_t  [NB];

    // per-test observation trackers
    int scen_cnt [NB];
    int mcen_cnt [NB];
    int db_hi    [NB];
    int scen_at  [NB];
    int fall_at  [NB];
    logic [NB-1:0] prev_db;

    task automatic chk(input string tag, input logic [NB-1:0] obs,
                       input logic [NB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms1 = '0;
        ms2 = '0;
        e_db = '0;
        e_scen = '0;
        e_mcen = '0;
        for (int c = 0; c < NB; c++) begin
            pressed[c] = 0;
            jp[c] = 0;
            holding[c] = 0;
            hi_run[c] = 0;
            lo_run[c] = 0;
            hold_t[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] b);
        logic [NB-1:0] v;
        v = ms2;
        ms2 = ms1;
        ms1 = b;
        for (int c = 0; c < NB; c++) begin
            if (!pressed[c]) begin
                hi_run[c] = v[c] ? hi_run[c] + 1 : 0;
                if (hi_run[c] == D + 1) begin
                    pressed[c] = 1;
                    jp[c] = 1;
                    hi_run[c] = 0;
                end
            end else if (jp[c]) begin
                jp[c] = 0;
                holding[c] = 1;
                hold_t[c] = 0;
            end else if (holding[c]) begin
                if (v[c]) begin
                    hold_t[c]++;
                end else begin
                    holding[c] = 0;
                    lo_run[c] = 1;
                end
            end else begin
                if (v[c]) begin
                    holding[c] = 1;
                    hold_t[c] = 0;
                end else begin
                    lo_run[c]++;
                    if (lo_run[c] == D + 1) begin
                        pressed[c] = 0;
                        hi_run[c] = 0;
                    end
                end
            end
            e_db[c]   = pressed[c];
            e_scen[c] = jp[c];
            e_mcen[c] = jp[c] ||
                        (pressed[c] && holding[c] && hold_t[c] >= RD &&
                         ((hold_t[c] - RD) % RP) == RP - 1 && ms2[c]);
        end
    endtask

    task automatic clr();
        rel = 0;
        prev_db = db;
        for (int c = 0; c < NB; c++) begin
            scen_cnt[c] = 0;
            mcen_cnt[c] = 0;
            db_hi[c] = 0;
            scen_at[c] = -1;
            fall_at[c] = -1;
        end
    endtask

    task automatic step(input logic [NB-1:0] b);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
        chk("db", db, e_db);
        chk("scen", scen, e_scen);
        chk("mcen", mcen, e_mcen);
        for (int c = 0; c < NB; c++) begin
            if (scen[c]) begin
                scen_cnt[c]++;
                scen_at[c] = rel;
            end
            if (mcen[c]) mcen_cnt[c]++;
            if (db[c]) db_hi[c]++;
            if (prev_db[c] && !db[c]) fall_at[c] = rel;
        end
        prev_db = db;
        rel++;
        cyc++;
    endtask

    task automatic run(input logic [NB-1:0] b, input int n);
        for (int k = 0; k < n; k++) step(b);
    endtask

    initial begin
        logic [NB-1:0] rb;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_db", db, '0);
        chk("rst_scen", scen, '0);
        chk("rst_mcen", mcen, '0);
        rst = 1'b0;
        run('0, 3);

        // clean press on left
        clr();
        run(5'b00100, 8);
        run('0, 10);
        chk_i("t1_scen_at", scen_at[2], 6);
        chk_i("t1_scen_cnt", scen_cnt[2], 1);
        chk_i("t1_mcen_cnt", mcen_cnt[2], 1);
        chk_i("t1_db_fall", fall_at[2], 14);

        // short bounces on up never accepted
        clr();
        run(5'b00001, 3);
        run('0, 1);
        run(5'b00001, 3);
        run('0, 8);
        chk_i("t2_scen_cnt", scen_cnt[0], 0);
        chk_i("t2_mcen_cnt", mcen_cnt[0], 0);
        chk_i("t2_db_hi", db_hi[0], 0);

        // long hold on right with auto-repeat
        clr();
        run(5'b01000, 40);
        run('0, 12);
        chk_i("t3_scen_at", scen_at[3], 6);
        chk_i("t3_scen_cnt", scen_cnt[3], 1);
        chk_i("t3_mcen_cnt", mcen_cnt[3], 9);
        chk_i("t3_db_hi", db_hi[3], 40);

        // release chatter on down
        clr();
        run(5'b00010, 10);
        run('0, 2);
        run(5'b00010, 1);
        run('0, 2);
        run(5'b00010, 1);
        run('0, 12);
        chk_i("t4_scen_cnt", scen_cnt[1], 1);
        chk("t4_db_final", db, '0);

        // simultaneous up and centre
        clr();
        run(5'b10001, 8);
        run(5'b10000, 4);
        run('0, 12);
        chk_i("t5_scen_at0", scen_at[0], 6);
        chk_i("t5_scen_at4", scen_at[4], 6);
        chk_i("t5_fall0", fall_at[0], 14);
        chk_i("t5_fall4", fall_at[4], 18);

        // reset during repeat on right
        clr();
        run(5'b01000, 20);
        rst = 1'b1;
        #1;
        chk("t6_db", db, '0);
        chk("t6_scen", scen, '0);
        chk("t6_mcen", mcen, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clr();
        run(5'b01000, 10);
        chk_i("t6_scen_at", scen_at[3], 6);
        chk_i("t6_scen_cnt", scen_cnt[3], 1);
        run('0, 12);

        // random chatter on all channels
        clr();
        rb = '0;
        for (int k = 0; k < 1200; k++) begin
            for (int c = 0; c < NB; c++)
                if ($urandom_range(0, 9) == 0) rb[c] = ~rb[c];
            step(rb);
        end
        run('0, 15);
        chk("rand_db_final", db, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
